// File: rtl/controle_servo_rampa_pkg.sv
// Purpose : shared servo timing constants and the ramp FSM state encoding.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package controle_servo_rampa_pkg;

    // Defaults for a standard hobby servo clocked at 50 MHz.
    localparam int SERVO_PERIODO_20MS  = 1000000;
    localparam int SERVO_LARGURA_MIN   = 35000;
    localparam int SERVO_LARGURA_PASSO = 10700;

    // PARADO: applied width equals target. RAMPA: still moving toward it.
    typedef enum logic {
        PARADO = 1'b0,
        RAMPA  = 1'b1
    } estado_t;

endpackage

// File: rtl/contador_periodo.sv
// Purpose : free-running modulo-MODULO counter with a last-count strobe, for PWM blocks.
// Latency : cnt advances every clock; fim_periodo is combinational from cnt.
// Backpressure: none; it never stalls.
//
// Ports: clock, reset (async, active-high), cnt (0..MODULO-1), fim_periodo (cnt==MODULO-1).
module contador_periodo #(
    parameter int MODULO = 1000000,
    parameter int W      = $clog2(MODULO + 1)
) (
    input  logic         clock,
    input  logic         reset,
    output logic [W-1:0] cnt,
    output logic         fim_periodo
);

    localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

    assign fim_periodo = (cnt == ULTIMO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (fim_periodo) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/controle_servo_rampa.sv
// Purpose : servo PWM whose pulse width is linear in a captured position, updated only at
//           period boundaries, with an optional per-period slew limit and a ready flag.
// Latency : controle lags the period counter by one clock; a load shows on the pulse at the
//           next boundary; pronto drops the cycle after a load that changes the target.
// Backpressure: none; upstream sequences on pronto.
//
// Ports: clock, reset (async, active-high), posicao/carrega (position + load strobe),
//        controle (PWM pin), pronto (width == target), db_* (debug copies of internal state).
module controle_servo_rampa
    import controle_servo_rampa_pkg::*;
#(
    parameter int   CONF_PERIODO  = SERVO_PERIODO_20MS,
    parameter int   POS_BITS      = 3,
    parameter int   LARGURA_MIN   = SERVO_LARGURA_MIN,
    parameter int   LARGURA_PASSO = SERVO_LARGURA_PASSO,
    parameter int   PASSO_RAMPA   = 0,
    localparam int  W             = $clog2(CONF_PERIODO + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [POS_BITS-1:0] posicao,
    input  logic                carrega,
    output logic                controle,
    output logic                pronto,
    output logic                db_controle,
    output logic [POS_BITS-1:0] db_posicao,
    output logic [W-1:0]        db_largura
);

    // The widest pulse must fit inside the period, otherwise the servo never sees a low phase.
    if (LARGURA_MIN + (2**POS_BITS - 1) * LARGURA_PASSO > CONF_PERIODO) begin : g_chk_largura
        $error("controle_servo_rampa: widest pulse exceeds CONF_PERIODO");
    end

    // A step larger than the period behaves like a direct jump; clamping keeps it within W bits.
    localparam int PASSO_EF = (PASSO_RAMPA > CONF_PERIODO) ? CONF_PERIODO : PASSO_RAMPA;
    localparam logic [W-1:0] PASSO   = W'(PASSO_EF);
    localparam logic [W-1:0] LMIN    = W'(LARGURA_MIN);
    localparam logic [W-1:0] LPASSO  = W'(LARGURA_PASSO);

    logic [W-1:0]        cnt;
    logic                fim_periodo;
    logic [POS_BITS-1:0] pos_reg;
    logic [W-1:0]        largura_atual;
    logic [W-1:0]        largura_alvo;
    logic [W-1:0]        largura_prox;
    estado_t             estado;
    estado_t             estado_prox;

    contador_periodo #(
        .MODULO (CONF_PERIODO),
        .W      (W)
    ) u_contador (
        .clock       (clock),
        .reset       (reset),
        .cnt         (cnt),
        .fim_periodo (fim_periodo)
    );

    // Bounded by the elaboration check above, so W bits cannot overflow.
    assign largura_alvo = LMIN + W'(pos_reg) * LPASSO;

    // Width the next edge will apply; it only moves on the last count of a period so that
    // no pulse is ever cut short or stretched mid-period.
    always_comb begin
        largura_prox = largura_atual;
        if (fim_periodo) begin
            if (PASSO_EF == 0) begin
                largura_prox = largura_alvo;
            end else if (largura_alvo > largura_atual) begin
                largura_prox = (largura_alvo - largura_atual > PASSO) ?
                               largura_atual + PASSO : largura_alvo;
            end else if (largura_alvo < largura_atual) begin
                largura_prox = (largura_atual - largura_alvo > PASSO) ?
                               largura_atual - PASSO : largura_alvo;
            end
        end
    end

    // Judged against the post-update width so a boundary that lands exactly on the target
    // returns to PARADO on that same edge.
    always_comb begin
        estado_prox = estado;
        case (estado)
            PARADO:  if (largura_prox != largura_alvo) estado_prox = RAMPA;
            RAMPA:   if (largura_prox == largura_alvo) estado_prox = PARADO;
            default: estado_prox = PARADO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= PARADO;
            pos_reg       <= '0;
            largura_atual <= LMIN;
            controle      <= 1'b0;
        end else begin
            estado        <= estado_prox;
            largura_atual <= largura_prox;
            controle      <= (cnt < largura_atual);
            if (carrega) begin
                pos_reg <= posicao;
            end
        end
    end

    assign pronto      = (estado == PARADO);
    assign db_controle = controle;
    assign db_posicao  = pos_reg;
    assign db_largura  = largura_atual;

endmodule

// File: tb/tb_controle_servo_rampa.sv
// Purpose : directed check of controle_servo_rampa with a direct-jump and a slew-limited instance.
// Latency : stimulus is driven #1 after a rising edge and outputs are sampled there too.
// Backpressure: n/a.
module tb_controle_servo_rampa;

    localparam int W = 7;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   posicao0, posicao1;
    logic         carrega0, carrega1;
    logic         controle0, pronto0, db_controle0;
    logic         controle1, pronto1, db_controle1;
    logic [2:0]   db_posicao0, db_posicao1;
    logic [W-1:0] db_largura0, db_largura1;

    int n_tot  = 0;
    int n_pass = 0;
    int c      = 0;   // expected period-counter value, tracked by the bench

    always #5 clock = ~clock;

    controle_servo_rampa #(
        .CONF_PERIODO(100), .POS_BITS(3), .LARGURA_MIN(10), .LARGURA_PASSO(10), .PASSO_RAMPA(0)
    ) u_dut0 (
        .clock(clock), .reset(reset), .posicao(posicao0), .carrega(carrega0),
        .controle(controle0), .pronto(pronto0), .db_controle(db_controle0),
        .db_posicao(db_posicao0), .db_largura(db_largura0)
    );

    controle_servo_rampa #(
        .CONF_PERIODO(100), .POS_BITS(3), .LARGURA_MIN(10), .LARGURA_PASSO(10), .PASSO_RAMPA(25)
    ) u_dut1 (
        .clock(clock), .reset(reset), .posicao(posicao1), .carrega(carrega1),
        .controle(controle1), .pronto(pronto1), .db_controle(db_controle1),
        .db_posicao(db_posicao1), .db_largura(db_largura1)
    );

    typedef struct {
        int         at;      // bench counter value at which to check
        logic       ld;      // load after checking
        logic [2:0] pos;     // position to load
        logic       e_ctrl;
        logic       e_pronto;
        int         e_larg;
        int         e_pos;
    } vec_t;

    vec_t tab[14];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (reset) c = 0;
        else       c = (c + 1) % 100;
    endtask

    task automatic wait_cnt(input int target);
        int k = 0;
        while (c != target && k < 250) begin
            tick();
            k++;
        end
        if (c != target) chk("wait_timeout", c, target);
    endtask

    task automatic load0(input logic [2:0] p);
        carrega0 = 1'b1; posicao0 = p;
        tick();
        carrega0 = 1'b0;
    endtask

    task automatic load1(input logic [2:0] p);
        carrega1 = 1'b1; posicao1 = p;
        tick();
        carrega1 = 1'b0;
    endtask

    // Counts high cycles over one full period starting at c==0.
    task automatic count_high(output int h0, output int h1);
        h0 = 0; h1 = 0;
        repeat (100) begin
            tick();
            h0 += int'(controle0);
            h1 += int'(controle1);
        end
    endtask

    initial begin
        int h0, h1;

        //             at  ld  pos  ctrl pronto larg pos
        tab[0]  = '{40, 1'b1, 3'd7, 1'b0, 1'b1, 10, 0};  // load 7 at cnt=40
        tab[1]  = '{42, 1'b0, 3'd0, 1'b0, 1'b0, 10, 7};  // pronto dropped, width held
        tab[2]  = '{99, 1'b0, 3'd0, 1'b0, 1'b0, 10, 7};
        tab[3]  = '{ 0, 1'b0, 3'd0, 1'b0, 1'b1, 80, 7};  // boundary: jump to 80
        tab[4]  = '{ 1, 1'b0, 3'd0, 1'b1, 1'b1, 80, 7};
        tab[5]  = '{80, 1'b0, 3'd0, 1'b1, 1'b1, 80, 7};
        tab[6]  = '{81, 1'b0, 3'd0, 1'b0, 1'b1, 80, 7};  // 80 clocks high
        tab[7]  = '{98, 1'b1, 3'd2, 1'b0, 1'b1, 80, 7};  // load 2 at cnt=98
        tab[8]  = '{99, 1'b1, 3'd5, 1'b0, 1'b1, 80, 2};  // load 5 at cnt=99
        tab[9]  = '{ 0, 1'b0, 3'd0, 1'b0, 1'b1, 30, 5};  // cnt=98 load applied
        tab[10] = '{ 2, 1'b0, 3'd0, 1'b1, 1'b0, 30, 5};  // cnt=99 load pending
        tab[11] = '{ 0, 1'b0, 3'd0, 1'b0, 1'b1, 60, 5};  // applied one period later
        tab[12] = '{60, 1'b0, 3'd0, 1'b1, 1'b1, 60, 5};
        tab[13] = '{61, 1'b0, 3'd0, 1'b0, 1'b1, 60, 5};

        reset = 1'b1;
        carrega0 = 1'b0; carrega1 = 1'b0;
        posicao0 = 3'd0; posicao1 = 3'd0;
        tick(); tick();

        // Reset state
        chk("rst controle0", int'(controle0), 0);
        chk("rst pronto0", int'(pronto0), 1);
        chk("rst largura0", int'(db_largura0), 10);
        chk("rst posicao0", int'(db_posicao0), 0);
        chk("rst controle1", int'(controle1), 0);
        chk("rst pronto1", int'(pronto1), 1);
        chk("rst largura1", int'(db_largura1), 10);

        reset = 1'b0;
        tick();
        chk("first edge controle0", int'(controle0), 1);
        wait_cnt(0);
        count_high(h0, h1);
        chk("idle high count dut0", h0, 10);
        chk("idle high count dut1", h1, 10);

        // Direct-jump instance: table of vectors
        for (int i = 0; i < 14; i++) begin
            wait_cnt(tab[i].at);
            chk($sformatf("v%0d controle", i), int'(controle0), int'(tab[i].e_ctrl));
            chk($sformatf("v%0d db_controle", i), int'(db_controle0), int'(tab[i].e_ctrl));
            chk($sformatf("v%0d pronto", i), int'(pronto0), int'(tab[i].e_pronto));
            chk($sformatf("v%0d largura", i), int'(db_largura0), tab[i].e_larg);
            chk($sformatf("v%0d posicao", i), int'(db_posicao0), tab[i].e_pos);
            if (tab[i].ld) load0(tab[i].pos);
        end

        // Ramp 10 -> 80 in steps of 25
        wait_cnt(20);
        load1(3'd7);
        tick();
        chk("ramp pronto after load", int'(pronto1), 0);
        chk("ramp width held", int'(db_largura1), 10);
        wait_cnt(0);
        chk("ramp b1 largura", int'(db_largura1), 35);
        chk("ramp b1 pronto", int'(pronto1), 0);
        count_high(h0, h1);
        chk("ramp b1 high count", h1, 35);
        chk("dut0 high count 60", h0, 60);
        chk("ramp b2 largura", int'(db_largura1), 60);
        chk("ramp b2 pronto", int'(pronto1), 0);
        tick();
        wait_cnt(0);
        chk("ramp b3 largura", int'(db_largura1), 80);
        chk("ramp b3 pronto", int'(pronto1), 1);

        // Reset in the middle of an 80-wide pulse
        wait_cnt(5);
        chk("pre-reset controle1", int'(controle1), 1);
        reset = 1'b1;
        #1;
        c = 0;
        chk("mid-reset controle1", int'(controle1), 0);
        chk("mid-reset db_controle1", int'(db_controle1), 0);
        chk("mid-reset pronto1", int'(pronto1), 1);
        chk("mid-reset largura1", int'(db_largura1), 10);
        chk("mid-reset posicao1", int'(db_posicao1), 0);
        chk("mid-reset largura0", int'(db_largura0), 10);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("post-reset cnt0 high", int'(controle1), 1);
        wait_cnt(10);
        chk("post-reset cnt9 high", int'(controle1), 1);
        wait_cnt(11);
        chk("post-reset cnt10 low", int'(controle1), 0);

        // Redirect mid-ramp: 7 then 2 after the first boundary
        wait_cnt(30);
        load1(3'd7);
        wait_cnt(0);
        chk("redir b1 largura", int'(db_largura1), 35);
        chk("redir b1 pronto", int'(pronto1), 0);
        wait_cnt(10);
        load1(3'd2);
        tick();
        chk("redir pronto pending", int'(pronto1), 0);
        chk("redir posicao", int'(db_posicao1), 2);
        wait_cnt(0);
        chk("redir b2 largura", int'(db_largura1), 30);
        chk("redir b2 pronto", int'(pronto1), 1);
        count_high(h0, h1);
        chk("redir high count", h1, 30);
        chk("dut0 post-reset high count", h0, 10);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
